router_pkt_tx: RTL and testbench

Packet transmitter that drives the input side of the 1x3 router. It collects a host-supplied payload into an internal buffer and computes the even byte-XOR parity. It then serialises header, payload and parity onto the router's `pkt_valid`/data bus, honouring the router's `busy` back-pressure. It sits in the source/test-harness domain upstream of the router top.

---
 rtl/router_pkt_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_tx
// Description : Packet transmitter feeding the 1x3 router input. Buffers a
//               host payload, accumulates even byte-XOR parity, then sends
//               header, payload and parity under router busy back-pressure.
// Options     : ROUTER_TX_CORRUPT_EN adds a 'corrupt' input that inverts the
//               transmitted parity byte of the packet it was started with.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef ROUTER_TX_CORRUPT_EN
  input  logic             corrupt,
`endif
  input  logic [1:0]       dest_addr,
  input  logic [5:0]       payload_len,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic             busy,
  output logic             pkt_valid,
  output logic [7:0]       data_out,
  output logic             tx_active,
  output logic             tx_done,
  output logic             reject,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic [1:0]       addr_q,      addr_d;
  logic [5:0]       len_q,       len_d;
  logic [5:0]       wptr_q,      wptr_d;
  logic [5:0]       rptr_q,      rptr_d;
  logic [7:0]       parity_q,    parity_d;
  logic             pl_ready_q,  pl_ready_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [7:0]       data_out_q,  data_out_d;
  logic             tx_active_q, tx_active_d;
  logic             tx_done_q,   tx_done_d;
  logic             reject_q,    reject_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic             buf_we;
  logic [7:0]       header;
  logic [7:0]       par_mask;

  // Payload store; contents are don't-care after reset, so it has no reset.
  logic [7:0]       buf_mem [0:62];

  assign header = {len_q, addr_q};

`ifdef ROUTER_TX_CORRUPT_EN
  logic             corrupt_q,   corrupt_d;
  assign par_mask = {8{corrupt_q}};
`else
  assign par_mask = 8'h00;
`endif

  // Next-state and next-output computation; everything holds unless changed.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    parity_d    = parity_q;
    pl_ready_d  = pl_ready_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    reject_d    = 1'b0;
    pkt_count_d = pkt_count_q;
    buf_we      = 1'b0;
`ifdef ROUTER_TX_CORRUPT_EN
    corrupt_d   = corrupt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((dest_addr != 2'd3) && (payload_len != 6'd0)) begin
            state_d     = S_LOAD;
            addr_d      = dest_addr;
            len_d       = payload_len;
            wptr_d      = 6'd0;
            parity_d    = 8'h00;
            pl_ready_d  = 1'b1;
            tx_active_d = 1'b1;
`ifdef ROUTER_TX_CORRUPT_EN
            corrupt_d   = corrupt;
`endif
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (pl_valid && pl_ready_q) begin
          buf_we   = 1'b1;
          wptr_d   = wptr_q + 6'd1;
          parity_d = parity_q ^ pl_data;
          if (wptr_q == (len_q - 6'd1)) begin
            // Fold the header into parity now so PARITY needs no extra step.
            state_d     = S_HEADER;
            parity_d    = parity_q ^ pl_data ^ header;
            pl_ready_d  = 1'b0;
            pkt_valid_d = 1'b1;
            data_out_d  = header;
          end
        end
      end

      S_HEADER: begin
        if (!busy) begin
          state_d    = S_PAYLOAD;
          data_out_d = buf_mem[0];
          rptr_d     = 6'd1;
        end
      end

      S_PAYLOAD: begin
        // rptr_q is the index of the byte after the one on the bus.
        if (!busy) begin
          if (rptr_q == len_q) begin
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            data_out_d  = parity_q ^ par_mask;
          end else begin
            data_out_d  = buf_mem[rptr_q];
            rptr_d      = rptr_q + 6'd1;
          end
        end
      end

      S_PARITY: begin
        if (!busy) begin
          state_d     = S_IDLE;
          data_out_d  = 8'h00;
          tx_active_d = 1'b0;
          tx_done_d   = 1'b1;
          pkt_count_d = pkt_count_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        pl_ready_d  = 1'b0;
        pkt_valid_d = 1'b0;
        data_out_d  = 8'h00;
        tx_active_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      wptr_q      <= 6'd0;
      rptr_q      <= 6'd0;
      parity_q    <= 8'h00;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'h00;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
      reject_q    <= 1'b0;
      pkt_count_q <= '0;
`ifdef ROUTER_TX_CORRUPT_EN
      corrupt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      parity_q    <= parity_d;
      pl_ready_q  <= pl_ready_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
      reject_q    <= reject_d;
      pkt_count_q <= pkt_count_d;
`ifdef ROUTER_TX_CORRUPT_EN
      corrupt_q   <= corrupt_d;
`endif
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clock) begin
    if (buf_we) begin
      buf_mem[wptr_q] <= pl_data;
    end
  end

  assign pl_ready  = pl_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign tx_active = tx_active_q;
  assign tx_done   = tx_done_q;
  assign reject    = reject_q;
  assign pkt_count = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Directed bench for router_pkt_tx with a queue-based packet
//               model checked every cycle, plus literal wire-sequence checks.
//               Define ROUTER_TX_CORRUPT_EN to include the corrupt-parity test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        corrupt = 1'b0;
  logic [1:0]  dest_addr = 2'd0;
  logic [5:0]  payload_len = 6'd0;
  logic [7:0]  pl_data = 8'h00;
  logic        pl_valid = 1'b0;
  logic        busy = 1'b0;
  logic        pl_ready, pkt_valid, tx_active, tx_done, reject;
  logic [7:0]  data_out;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int b2_cycles = 0;

  logic [8:0] wire_log [$];
  logic [7:0] pl_vec [0:3];

  router_pkt_tx #(.CNT_W(16)) dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
`ifdef ROUTER_TX_CORRUPT_EN
    .corrupt     (corrupt),
`endif
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .data_out    (data_out),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .reject      (reject),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: packets as byte queues -------------
  int         m_mode = 0;          // 0 idle, 1 collecting payload, 2 sending
  logic [1:0] m_addr;
  logic [5:0] m_len;
  bit         m_corr;
  bit         m_done = 0, m_rej = 0;
  logic [15:0] m_count = 0;
  logic [7:0] q_pl [$];
  logic [8:0] q_wire [$];

  always @(posedge clk) begin
    logic [7:0] hdr, par;
    if (reset) begin
      m_mode = 0; q_pl.delete(); q_wire.delete();
      m_count = 0; m_done = 0; m_rej = 0;
    end else begin
      m_done = 0; m_rej = 0;
      case (m_mode)
        0: if (start) begin
             if (dest_addr != 2'd3 && payload_len != 6'd0) begin
               m_mode = 1; m_addr = dest_addr; m_len = payload_len;
               q_pl.delete();
`ifdef ROUTER_TX_CORRUPT_EN
               m_corr = corrupt;
`else
               m_corr = 1'b0;
`endif
             end else m_rej = 1;
           end
        1: if (pl_valid) begin
             q_pl.push_back(pl_data);
             if (q_pl.size() == int'(m_len)) begin
               hdr = {m_len, m_addr};
               par = hdr;
               q_wire.push_back({1'b1, hdr});
               foreach (q_pl[k]) begin
                 q_wire.push_back({1'b1, q_pl[k]});
                 par = par ^ q_pl[k];
               end
               q_wire.push_back({1'b0, m_corr ? ~par : par});
               m_mode = 2;
             end
           end
        default: if (!busy) begin
             void'(q_wire.pop_front());
             if (q_wire.size() == 0) begin
               m_mode = 0; m_done = 1; m_count = m_count + 16'd1;
             end
           end
      endcase
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [8:0] w;
    logic [28:0] exp_v, act_v;
    if (chk_en) begin
      w = (m_mode == 2 && q_wire.size() != 0) ? q_wire[0] : 9'h000;
      exp_v = {m_mode == 1, m_mode != 0, w, m_done, m_rej, m_count};
      act_v = {pl_ready, tx_active, pkt_valid, data_out, tx_done, reject, pkt_count};
      chk("cycle {rdy,act,pv,data,done,rej,cnt}", 64'(act_v), 64'(exp_v));
    end
    if (pkt_valid && data_out == 8'hB2) b2_cycles++;
  end

  // Record every byte the router actually consumes.
  always @(posedge clk) begin
    if (!reset && tx_active && !pl_ready && !busy)
      wire_log.push_back({pkt_valid, data_out});
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l, input logic c);
    start = 1'b1; dest_addr = a; payload_len = l; corrupt = c;
    tick;
    start = 1'b0; corrupt = 1'b0;
  endtask

  // vmask bit k gives pl_valid in the k-th collection cycle; then always 1.
  task automatic drive_payload(input int n, input logic [15:0] vmask);
    int i = 0;
    int k = 0;
    while (i < n) begin
      pl_valid = (k < 16) ? vmask[k] : 1'b1;
      pl_data  = pl_vec[i];
      tick;
      if (pl_valid) i++;
      k++;
    end
    pl_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (tx_done !== 1'b1 && k < 200) begin tick; k++; end
    chk({nm, " tx_done seen"}, 64'(tx_done), 64'd1);
  endtask

  task automatic check_wire(input string nm, input logic [8:0] e0, e1, e2, e3, e4);
    logic [8:0] e [0:4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    chk({nm, " byte count"}, 64'(wire_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < wire_log.size(); k++)
      chk($sformatf("%s byte%0d {pv,data}", nm, k), 64'(wire_log[k]), 64'(e[k]));
  endtask

  initial begin
    tick; tick;
    chk("reset pkt_count", 64'(pkt_count), 64'd0);
    chk("reset tx_active", 64'(tx_active), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick;

    // Basic packet: addr 1, len 3.
    pl_vec[0] = 8'hA1; pl_vec[1] = 8'hB2; pl_vec[2] = 8'hC3;
    wire_log.delete();
    start_pkt(2'd1, 6'd3, 1'b0);
    chk("load pl_ready", 64'(pl_ready), 64'd1);
    drive_payload(3, 16'hFFFF);
    wait_done("basic");
    check_wire("basic", 9'h10D, 9'h1A1, 9'h1B2, 9'h1C3, 9'h0DD);
    chk("basic pkt_count", 64'(pkt_count), 64'd1);
    tick;

    // Busy held for two cycles while B2 is on the bus.
    wire_log.delete();
    start_pkt(2'd1, 6'd3, 1'b0);
    drive_payload(3, 16'hFFFF);
    tick; tick;
    b2_cycles = 0;
    chk("busy B2 on bus", 64'(data_out), 64'hB2);
    busy = 1'b1; tick; tick; busy = 1'b0;
    wait_done("busy");
    check_wire("busy", 9'h10D, 9'h1A1, 9'h1B2, 9'h1C3, 9'h0DD);
    chk("busy B2 cycles", 64'(b2_cycles), 64'd3);
    chk("busy pkt_count", 64'(pkt_count), 64'd2);
    tick;

    // Illegal starts.
    start_pkt(2'd3, 6'd3, 1'b0);
    chk("addr3 reject", 64'(reject), 64'd1);
    chk("addr3 tx_active", 64'(tx_active), 64'd0);
    tick;
    chk("addr3 reject gone", 64'(reject), 64'd0);
    start_pkt(2'd1, 6'd0, 1'b0);
    chk("len0 reject", 64'(reject), 64'd1);
    chk("len0 tx_active", 64'(tx_active), 64'd0);
    tick;
    chk("len0 reject gone", 64'(reject), 64'd0);
    chk("illegal pkt_count", 64'(pkt_count), 64'd2);

    // Gapped payload, then a start pulse during PAYLOAD.
    pl_vec[0] = 8'h11; pl_vec[1] = 8'h22; pl_vec[2] = 8'h33;
    wire_log.delete();
    start_pkt(2'd2, 6'd3, 1'b0);
    drive_payload(3, 16'h0019);
    chk("gap header pkt_valid", 64'(pkt_valid), 64'd1);
    chk("gap header byte", 64'(data_out), 64'h0E);
    tick;
    start_pkt(2'd1, 6'd2, 1'b0);
    wait_done("gap");
    check_wire("gap", 9'h10E, 9'h111, 9'h122, 9'h133, 9'h00E);
    chk("gap pkt_count", 64'(pkt_count), 64'd3);
    tick;

    // Reset mid-payload, then a fresh packet.
    pl_vec[0] = 8'hA1; pl_vec[1] = 8'hB2; pl_vec[2] = 8'hC3;
    start_pkt(2'd1, 6'd3, 1'b0);
    drive_payload(3, 16'hFFFF);
    tick; tick;
    reset = 1'b1; tick; reset = 1'b0;
    chk("rst pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst data_out", 64'(data_out), 64'd0);
    chk("rst tx_active", 64'(tx_active), 64'd0);
    chk("rst pkt_count", 64'(pkt_count), 64'd0);
    tick;
    wire_log.delete();
    start_pkt(2'd1, 6'd3, 1'b0);
    drive_payload(3, 16'hFFFF);
    wait_done("post-reset");
    check_wire("post-reset", 9'h10D, 9'h1A1, 9'h1B2, 9'h1C3, 9'h0DD);
    chk("post-reset pkt_count", 64'(pkt_count), 64'd1);
    tick;

`ifdef ROUTER_TX_CORRUPT_EN
    wire_log.delete();
    start_pkt(2'd1, 6'd3, 1'b1);
    drive_payload(3, 16'hFFFF);
    wait_done("corrupt");
    check_wire("corrupt", 9'h10D, 9'h1A1, 9'h1B2, 9'h1C3, 9'h022);
    tick;
    wire_log.delete();
    start_pkt(2'd1, 6'd3, 1'b0);
    drive_payload(3, 16'hFFFF);
    wait_done("clean");
    check_wire("clean", 9'h10D, 9'h1A1, 9'h1B2, 9'h1C3, 9'h0DD);
    tick;
`endif

    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
